// File: rtl/temp_poll_ctrl.sv
// temp_poll_ctrl
//   Sequencer in front of an I2C byte master. It writes a two-byte config to
//   each of N_SENS temperature sensors once, then reads them round-robin with
//   POLL_CYC idle clocks between rounds. Each reading is turned into
//   sign + integer magnitude. Every wait for the master is bounded by TIMEOUT;
//   an expired wait flags the channel in err and moves on to the next one.
module temp_poll_ctrl #(
    parameter int         N_SENS    = 4,
    parameter logic [6:0] ADDR_BASE = 7'h48,
    parameter logic [7:0] CONF_PTR  = 8'h01,
    parameter logic [7:0] TEMP_PTR  = 8'h00,
    parameter logic [7:0] CONF_B1   = 8'h60,
    parameter logic [7:0] CONF_B2   = 8'hA0,
    parameter int         POLL_CYC  = 100000,
    parameter int         TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                done,
    input  logic                ready,
    input  logic [7:0]          drd,
    output logic                go,
    output logic                rw,
    output logic [1:0]          n_byte,
    output logic [7:0]          r_pointer,
    output logic [6:0]          dev_add,
    output logic [7:0]          dwr,
    output logic [N_SENS-1:0]   temp_sign,
    output logic [9*N_SENS-1:0] temp_mag,
    output logic [N_SENS-1:0]   temp_valid,
    output logic [N_SENS-1:0]   err,
    output logic                upd,
    output logic [2:0]          upd_ch
);

    // Channel index width; kept exact so per-channel selects are never oversized.
    localparam int CHW = (N_SENS > 1) ? $clog2(N_SENS) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(N_SENS - 1);

    // One shared counter serves both the poll interval and the wait timeout.
    localparam int CNT_MAX = (POLL_CYC > TIMEOUT) ? POLL_CYC : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYC - 1);

    // EM bit of the config byte selects 13-bit (shift 3) or 12-bit (shift 4) data.
    localparam logic EM    = CONF_B2[4];
    localparam int   SHIFT = EM ? 3 : 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_GO,
        S_CFG_B1,
        S_CFG_B2,
        S_CFG_END,
        S_RD_GO,
        S_RD_B1,
        S_RD_B2,
        S_CONV,
        S_RD_END,
        S_NEXT,
        S_POLL
    } state_t;

    state_t              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [N_SENS-1:0]   cfg_ok_q, cfg_ok_d;
    logic                started_q, started_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         data_q, data_d;

    logic                rw_q, rw_d;
    logic [1:0]          n_byte_q, n_byte_d;
    logic [7:0]          r_pointer_q, r_pointer_d;
    logic [6:0]          dev_add_q, dev_add_d;
    logic [7:0]          dwr_q, dwr_d;
    logic [N_SENS-1:0]   temp_sign_q, temp_sign_d;
    logic [9*N_SENS-1:0] temp_mag_q, temp_mag_d;
    logic [N_SENS-1:0]   temp_valid_q, temp_valid_d;
    logic [N_SENS-1:0]   err_q, err_d;
    logic                upd_q, upd_d;
    logic [2:0]          upd_ch_q, upd_ch_d;

    logic [N_SENS-1:0]   ch_sel;
    logic                is_wait;
    logic                tmo_hit;
    logic signed [15:0]  raw;
    logic [15:0]         raw_abs;
    logic                conv_sign;
    logic [8:0]          conv_mag;

    // One-hot decode of the current channel for all per-channel updates.
    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < N_SENS; k++) begin
            ch_sel[k] = (ch_q == CHW'(k));
        end
    end

    // Reading to sign + magnitude: arithmetic shift drops the unused low bits,
    // then |raw| >> 4 truncates the fraction toward zero.
    always_comb begin
        raw       = $signed(data_q) >>> SHIFT;
        raw_abs   = raw[15] ? -raw : raw;
        conv_sign = raw[15];
        conv_mag  = 9'(raw_abs >> 4);
    end

    // Wait states are timed; IDLE only after the first transaction was issued.
    always_comb begin
        case (state_q)
            S_IDLE:                       is_wait = started_q;
            S_CFG_B1, S_CFG_B2, S_CFG_END,
            S_RD_B1, S_RD_B2, S_RD_END:   is_wait = 1'b1;
            default:                      is_wait = 1'b0;
        endcase
        tmo_hit = is_wait && (cnt_q == TMO_LAST);
    end

    // Next-state, master fields, channel results and counter.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        ch_d         = ch_q;
        cfg_ok_d     = cfg_ok_q;
        started_d    = started_q;
        data_d       = data_q;
        rw_d         = rw_q;
        n_byte_d     = n_byte_q;
        r_pointer_d  = r_pointer_q;
        dev_add_d    = dev_add_q;
        dwr_d        = dwr_q;
        temp_sign_d  = temp_sign_q;
        temp_mag_d   = temp_mag_q;
        temp_valid_d = temp_valid_q;
        err_d        = err_q;
        upd_d        = 1'b0;
        upd_ch_d     = upd_ch_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (done) begin
                    state_d = ((cfg_ok_q & ch_sel) != '0) ? S_RD_GO : S_CFG_GO;
                end
            end
            S_CFG_GO: begin
                started_d = 1'b1;
                state_d   = S_CFG_B1;
            end
            S_CFG_B1: begin
                if (ready) begin
                    dwr_d   = CONF_B1;
                    state_d = S_CFG_B2;
                end
            end
            S_CFG_B2: begin
                if (ready) begin
                    dwr_d   = CONF_B2;
                    state_d = S_CFG_END;
                end
            end
            S_CFG_END: begin
                if (done) begin
                    cfg_ok_d = cfg_ok_q | ch_sel;
                    err_d    = err_q & ~ch_sel;
                    state_d  = S_RD_GO;
                end
            end
            S_RD_GO: begin
                started_d = 1'b1;
                state_d   = S_RD_B1;
            end
            S_RD_B1: begin
                if (ready) begin
                    data_d[15:8] = drd;
                    state_d      = S_RD_B2;
                end
            end
            S_RD_B2: begin
                if (ready) begin
                    data_d[7:0] = drd;
                    state_d     = S_CONV;
                end
            end
            S_CONV: begin
                temp_sign_d  = (temp_sign_q & ~ch_sel) | (ch_sel & {N_SENS{conv_sign}});
                temp_valid_d = temp_valid_q | ch_sel;
                for (int k = 0; k < N_SENS; k++) begin
                    if (ch_sel[k]) begin
                        temp_mag_d[9*k +: 9] = conv_mag;
                    end
                end
                state_d = S_RD_END;
            end
            S_RD_END: begin
                if (done) begin
                    upd_d    = 1'b1;
                    upd_ch_d = 3'(ch_q);
                    err_d    = err_q & ~ch_sel;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (ch_q == LAST_CH) begin
                    ch_d    = '0;
                    state_d = S_POLL;
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    state_d = S_IDLE;
                end
            end
            S_POLL: begin
                if (cnt_q == POLL_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A wait that saw no event in its last allowed clock gives up on the
        // channel; results stay as they were, cfg_ok is not touched.
        if (tmo_hit && (state_d == state_q)) begin
            err_d    = err_q | ch_sel;
            upd_d    = 1'b1;
            upd_ch_d = 3'(ch_q);
            state_d  = S_NEXT;
        end

        // Master fields are loaded on entry to a go state and then held.
        if (state_d == S_CFG_GO) begin
            rw_d        = 1'b0;
            n_byte_d    = 2'd2;
            r_pointer_d = CONF_PTR;
            dev_add_d   = ADDR_BASE + 7'(ch_d);
        end else if (state_d == S_RD_GO) begin
            rw_d        = 1'b1;
            n_byte_d    = 2'd2;
            r_pointer_d = TEMP_PTR;
            dev_add_d   = ADDR_BASE + 7'(ch_d);
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_TOP) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            cfg_ok_q     <= '0;
            started_q    <= 1'b0;
            cnt_q        <= '0;
            data_q       <= '0;
            rw_q         <= 1'b0;
            n_byte_q     <= '0;
            r_pointer_q  <= '0;
            dev_add_q    <= '0;
            dwr_q        <= '0;
            temp_sign_q  <= '0;
            temp_mag_q   <= '0;
            temp_valid_q <= '0;
            err_q        <= '0;
            upd_q        <= 1'b0;
            upd_ch_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            ch_q         <= ch_d;
            cfg_ok_q     <= cfg_ok_d;
            started_q    <= started_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            rw_q         <= rw_d;
            n_byte_q     <= n_byte_d;
            r_pointer_q  <= r_pointer_d;
            dev_add_q    <= dev_add_d;
            dwr_q        <= dwr_d;
            temp_sign_q  <= temp_sign_d;
            temp_mag_q   <= temp_mag_d;
            temp_valid_q <= temp_valid_d;
            err_q        <= err_d;
            upd_q        <= upd_d;
            upd_ch_q     <= upd_ch_d;
        end
    end

    assign go         = (state_q == S_CFG_GO) || (state_q == S_RD_GO);
    assign rw         = rw_q;
    assign n_byte     = n_byte_q;
    assign r_pointer  = r_pointer_q;
    assign dev_add    = dev_add_q;
    assign dwr        = dwr_q;
    assign temp_sign  = temp_sign_q;
    assign temp_mag   = temp_mag_q;
    assign temp_valid = temp_valid_q;
    assign err        = err_q;
    assign upd        = upd_q;
    assign upd_ch     = upd_ch_q;

endmodule

// File: tb/tb_temp_poll_ctrl.sv
// tb_temp_poll_ctrl
//   Two sequencers (12-bit and 13-bit config) share one reactive I2C master
//   model. Conversion results come from a hand-computed vector table; the
//   multi-cycle cases (timeouts, config retry, mid-read reset) are sequences.
module tb_temp_poll_ctrl;

    localparam int N    = 2;
    localparam int POLL = 20;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        done  = 1'b1;
    logic        ready = 1'b0;
    logic [7:0]  drd   = 8'h00;

    logic        go_a, rw_a, upd_a;
    logic [1:0]  nb_a, sign_a, valid_a, err_a;
    logic [7:0]  ptr_a, dwr_a;
    logic [6:0]  dev_a;
    logic [17:0] mag_a;
    logic [2:0]  updch_a;

    logic        go_b, rw_b, upd_b;
    logic [1:0]  nb_b, sign_b, valid_b, err_b;
    logic [7:0]  ptr_b, dwr_b;
    logic [6:0]  dev_b;
    logic [17:0] mag_b;
    logic [2:0]  updch_b;

    temp_poll_ctrl #(.N_SENS(N), .CONF_B2(8'hA0), .POLL_CYC(POLL), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .reset(reset_n), .done(done), .ready(ready), .drd(drd),
        .go(go_a), .rw(rw_a), .n_byte(nb_a), .r_pointer(ptr_a), .dev_add(dev_a),
        .dwr(dwr_a), .temp_sign(sign_a), .temp_mag(mag_a), .temp_valid(valid_a),
        .err(err_a), .upd(upd_a), .upd_ch(updch_a)
    );

    temp_poll_ctrl #(.N_SENS(N), .CONF_B2(8'hB0), .POLL_CYC(POLL), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .reset(reset_n), .done(done), .ready(ready), .drd(drd),
        .go(go_b), .rw(rw_b), .n_byte(nb_b), .r_pointer(ptr_b), .dev_add(dev_b),
        .dwr(dwr_b), .temp_sign(sign_b), .temp_mag(mag_b), .temp_valid(valid_b),
        .err(err_b), .upd(upd_b), .upd_ch(updch_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Conversion vectors: bytes from the sensor, expected 12-bit and 13-bit results.
    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       s12;
        logic [8:0] m12;
        logic       s13;
        logic [8:0] m13;
    } vec_t;
    vec_t vecs [9];

    // Master-model control and transaction log.
    logic [7:0] rd_hi [N];
    logic [7:0] rd_lo [N];
    int         stall_rd  = -1;
    int         stall_cfg = -1;
    int         m_ph = 0;
    bit         m_stall;
    bit         m_rw;
    int         m_ch;
    int         log_n = 0;
    int         last_go_cyc = 0;
    logic       tr_rw  [64];
    logic [1:0] tr_nb  [64];
    logic [6:0] tr_dev [64];
    logic [7:0] tr_ptr [64];
    logic [7:0] tr_w1  [64];
    logic [7:0] tr_w2  [64];
    logic [7:0] tr_w2b [64];

    // Reactive master: on go drop done, strobe two bytes, raise done. A stalled
    // transaction sends no strobes and releases done just after the timeout.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_ph  = 0;
            done  = 1'b1;
            ready = 1'b0;
        end else begin
            ready = 1'b0;
            if (m_ph == 0) begin
                if (go_a) begin
                    m_rw    = rw_a;
                    m_ch    = int'(dev_a - 7'h48);
                    m_stall = (rw_a && m_ch == stall_rd) || (!rw_a && m_ch == stall_cfg);
                    if (log_n < 64) begin
                        tr_rw[log_n]  = rw_a;
                        tr_nb[log_n]  = nb_a;
                        tr_dev[log_n] = dev_a;
                        tr_ptr[log_n] = ptr_a;
                        tr_w1[log_n]  = 8'h00;
                        tr_w2[log_n]  = 8'h00;
                        tr_w2b[log_n] = 8'h00;
                    end
                    log_n++;
                    last_go_cyc = cyc;
                    done = 1'b0;
                    m_ph = 1;
                end
            end else begin
                m_ph++;
                if (m_stall) begin
                    if (m_ph == TMO + 4) begin
                        done = 1'b1;
                        m_ph = 0;
                    end
                end else begin
                    case (m_ph)
                        3: begin ready = 1'b1; drd = (m_ch == 1) ? rd_hi[1] : rd_hi[0]; end
                        4: if (!m_rw && log_n <= 64) tr_w1[log_n-1] = dwr_a;
                        5: begin ready = 1'b1; drd = (m_ch == 1) ? rd_lo[1] : rd_lo[0]; end
                        6: if (!m_rw && log_n <= 64) begin
                               tr_w2[log_n-1]  = dwr_a;
                               tr_w2b[log_n-1] = dwr_b;
                           end
                        7: begin done = 1'b1; m_ph = 0; end
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic set_data(input int i0, input int i1);
        rd_hi[0] = vecs[i0].hi;
        rd_lo[0] = vecs[i0].lo;
        rd_hi[1] = vecs[i1].hi;
        rd_lo[1] = vecs[i1].lo;
    endtask

    // Waits for the upd pulse of the last channel, which closes a round.
    task automatic wait_round(input string name, output int t_upd);
        bit seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (upd_a && updch_a == 3'd1) begin
                seen = 1'b1;
                break;
            end
        end
        t_upd = cyc;
        if (!seen) check({name, " round end"}, 32'd0, 32'd1);
    endtask

    task automatic check_conv(input string tag, input int i0, input int i1);
        check({tag, " a ch0 sign"}, 32'(sign_a[0]),   32'(vecs[i0].s12));
        check({tag, " a ch0 mag"},  32'(mag_a[8:0]),  32'(vecs[i0].m12));
        check({tag, " a ch1 sign"}, 32'(sign_a[1]),   32'(vecs[i1].s12));
        check({tag, " a ch1 mag"},  32'(mag_a[17:9]), 32'(vecs[i1].m12));
        check({tag, " b ch0 sign"}, 32'(sign_b[0]),   32'(vecs[i0].s13));
        check({tag, " b ch0 mag"},  32'(mag_b[8:0]),  32'(vecs[i0].m13));
        check({tag, " b ch1 sign"}, 32'(sign_b[1]),   32'(vecs[i1].s13));
        check({tag, " b ch1 mag"},  32'(mag_b[17:9]), 32'(vecs[i1].m13));
    endtask

    task automatic check_tr(input string tag, input int idx, input logic exp_rw, input logic [6:0] exp_dev);
        if (idx < log_n && idx < 64) begin
            check({tag, " rw"},     32'(tr_rw[idx]),  32'(exp_rw));
            check({tag, " dev"},    32'(tr_dev[idx]), 32'(exp_dev));
            check({tag, " ptr"},    32'(tr_ptr[idx]), exp_rw ? 32'h00 : 32'h01);
            check({tag, " n_byte"}, 32'(tr_nb[idx]),  32'd2);
        end else begin
            check({tag, " present"}, 32'(log_n), 32'(idx + 1));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " master a"}, 32'({go_a, rw_a, nb_a, ptr_a, dev_a, dwr_a}), 32'd0);
        check({tag, " temp a"},   32'({sign_a, mag_a, valid_a}), 32'd0);
        check({tag, " flags a"},  32'({err_a, upd_a, updch_a}), 32'd0);
        check({tag, " master b"}, 32'({go_b, rw_b, nb_b, ptr_b, dev_b, dwr_b}), 32'd0);
        check({tag, " temp b"},   32'({sign_b, mag_b, valid_b}), 32'd0);
        check({tag, " flags b"},  32'({err_b, upd_b, updch_b}), 32'd0);
    endtask

    initial begin
        int t_upd;
        int t0;
        int base;
        bit found;

        vecs[0] = '{8'h19, 8'h00, 1'b0, 9'd25,  1'b0, 9'd50};
        vecs[1] = '{8'hE7, 8'h00, 1'b1, 9'd25,  1'b1, 9'd50};
        vecs[2] = '{8'hFF, 8'hF0, 1'b1, 9'd0,   1'b1, 9'd0};
        vecs[3] = '{8'h4B, 8'h00, 1'b0, 9'd75,  1'b0, 9'd150};
        vecs[4] = '{8'h80, 8'h00, 1'b1, 9'd128, 1'b1, 9'd256};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 9'd0,   1'b0, 9'd0};
        vecs[6] = '{8'h7F, 8'hF8, 1'b0, 9'd127, 1'b0, 9'd255};
        vecs[7] = '{8'hFF, 8'h00, 1'b1, 9'd1,   1'b1, 9'd2};
        vecs[8] = '{8'hFE, 8'hF0, 1'b1, 9'd1,   1'b1, 9'd2};

        // Reset state.
        reset_n = 1'b0;
        set_data(0, 1);
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;

        // Round 1: config + read per channel, in channel order.
        wait_round("r1", t_upd);
        check("r1 go count", 32'(log_n), 32'd4);
        check_tr("r1 t0", 0, 1'b0, 7'h48);
        check("r1 cfg0 b1",   32'(tr_w1[0]),  32'h60);
        check("r1 cfg0 b2 a", 32'(tr_w2[0]),  32'hA0);
        check("r1 cfg0 b2 b", 32'(tr_w2b[0]), 32'hB0);
        check_tr("r1 t1", 1, 1'b1, 7'h48);
        check_tr("r1 t2", 2, 1'b0, 7'h49);
        check("r1 cfg1 b1",   32'(tr_w1[2]),  32'h60);
        check_tr("r1 t3", 3, 1'b1, 7'h49);
        check_conv("r1", 0, 1);
        check("r1 valid", 32'(valid_a), 32'd3);
        check("r1 err",   32'(err_a),   32'd0);

        // Poll interval: NEXT, POLL_CYC poll clocks, IDLE, then go.
        set_data(2, 3);
        t0 = cyc;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (go_a) begin
                found = 1'b1;
                break;
            end
        end
        check("poll gap", found ? 32'(cyc - t0) : 32'hFFFF, 32'(POLL + 2));

        // Round 2: reads only.
        wait_round("r2", t_upd);
        check("r2 go count", 32'(log_n), 32'd6);
        check_tr("r2 t4", 4, 1'b1, 7'h48);
        check_tr("r2 t5", 5, 1'b1, 7'h49);
        check_conv("r2", 2, 3);

        // Remaining conversion vectors, two per round.
        for (int j = 2; j < 5; j++) begin
            set_data(2 * j, (2 * j + 1) % 9);
            wait_round($sformatf("r%0d", j + 1), t_upd);
            check_conv($sformatf("r%0d", j + 1), 2 * j, (2 * j + 1) % 9);
        end

        // Channel 1 read stalls in RD_B1: timeout flags it, old reading kept.
        stall_rd = 1;
        set_data(1, 3);
        wait_round("rd tmo", t_upd);
        check("rd tmo latency", 32'(t_upd - last_go_cyc), 32'(TMO + 1));
        check("rd tmo err a",   32'(err_a), 32'b10);
        check("rd tmo err b",   32'(err_b), 32'b10);
        check_conv("rd tmo", 1, 0);
        stall_rd = -1;
        wait_round("rd recover", t_upd);
        check("rd recover err", 32'(err_a), 32'd0);
        check_conv("rd recover", 1, 3);

        // Config stall on channel 0 after reset: config retried next round.
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stall_cfg = 0;
        base = log_n;
        wait_round("cfg tmo", t_upd);
        check("cfg tmo go count", 32'(log_n - base), 32'd3);
        check_tr("cfg tmo t0", base,     1'b0, 7'h48);
        check_tr("cfg tmo t1", base + 1, 1'b0, 7'h49);
        check_tr("cfg tmo t2", base + 2, 1'b1, 7'h49);
        check("cfg tmo err",   32'(err_a),   32'b01);
        check("cfg tmo valid", 32'(valid_a), 32'b10);
        stall_cfg = -1;
        wait_round("cfg retry", t_upd);
        check_tr("cfg retry t3", base + 3, 1'b0, 7'h48);
        check_tr("cfg retry t4", base + 4, 1'b1, 7'h48);
        check_tr("cfg retry t5", base + 5, 1'b1, 7'h49);
        check("cfg retry err",   32'(err_a),   32'd0);
        check("cfg retry valid", 32'(valid_a), 32'b11);

        // Reset in RD_B2: outputs clear at once, restart from config on ch0.
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (m_ph == 4 && m_rw) begin
                found = 1'b1;
                break;
            end
        end
        check("reach rd_b2", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset("mid reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = log_n;
        wait_round("after reset", t_upd);
        check_tr("after reset t0", base,     1'b0, 7'h48);
        check_tr("after reset t1", base + 1, 1'b1, 7'h48);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
